// File: rtl/dual_pri_drain_pkg.sv
// Shared parameters, state encoding and popcount-threshold helpers for the
// dual-priority drain block.
package dual_pri_pkg;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic ge2(input logic [WIDTH-1:0] v);
    return ((v & (v - WIDTH'(1))) != '0);
  endfunction

  // Clearing the two lowest set bits leaves nothing only if at most two were set.
  function automatic logic le2(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] w;
    w = v & (v - WIDTH'(1));
    return ((w & (w - WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/dual_pri_drain_if.sv
// Request-in / grant-pair-out handshake bundle for dual_pri_drain.
interface dual_pri_drain_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_first;
  logic [IDX_W-1:0] out_second;
  logic             out_second_vld;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_first, out_second, out_second_vld, out_last, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_first, out_second, out_second_vld, out_last, busy
  );
endinterface

// File: rtl/dual_pri_drain_pri_enc_msb.sv
// Combinational MSB-first priority encoder: index of the highest set bit.
module pri_enc_msb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 0; i < WIDTH; i++) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/dual_pri_drain.sv
// Holds a multi-hot request vector and drains it two grants per beat,
// highest priority first, with zero-bubble reload on the last beat.
module dual_pri_drain
  import dual_pri_pkg::*;
#(
  parameter int WIDTH = dual_pri_pkg::WIDTH,
  parameter int IDX_W = dual_pri_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  dual_pri_drain_if.slave  bus
);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic [WIDTH-1:0] masked_s;
  logic [IDX_W-1:0] first_s, second_s;
  logic             first_any_s, second_any_s;
  logic             fire_s, last_s;

  pri_enc_msb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_first (
    .vec (pend_r),
    .idx (first_s),
    .any (first_any_s)
  );

  assign masked_s = pend_r & ~(WIDTH'(1) << first_s);

  pri_enc_msb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_second (
    .vec (masked_s),
    .idx (second_s),
    .any (second_any_s)
  );

  // Outputs come straight from pend_r, so they hold while the consumer stalls.
  assign last_s             = (state_r == DRAIN) && le2(pend_r);
  assign fire_s             = (state_r == DRAIN) && bus.out_ready;
  assign bus.out_valid      = (state_r == DRAIN);
  assign bus.busy           = (state_r == DRAIN);
  assign bus.out_first      = first_any_s ? first_s : '0;
  assign bus.out_second     = second_any_s ? second_s : '0;
  assign bus.out_second_vld = ge2(pend_r);
  assign bus.out_last       = last_s;
  assign bus.in_ready       = (state_r == IDLE) || (fire_s && last_s);

  // Next-state and pending-vector update.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && (bus.in_vec != '0)) begin
          pend_s  = bus.in_vec;
          state_s = DRAIN;
        end else begin
          pend_s  = '0;
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (fire_s && last_s) begin
          if (bus.in_valid && (bus.in_vec != '0)) begin
            pend_s  = bus.in_vec;
            state_s = DRAIN;
          end else begin
            pend_s  = '0;
            state_s = IDLE;
          end
        end else if (fire_s) begin
          pend_s  = masked_s & ~(WIDTH'(1) << second_s);
          state_s = DRAIN;
        end else begin
          pend_s  = pend_r;
          state_s = DRAIN;
        end
      end
      default: begin
        pend_s  = '0;
        state_s = IDLE;
      end
    endcase
  end

  // State and pending-vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pend_r  <= '0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
    end
  end

endmodule

// File: tb/tb_dual_pri_drain.sv
// Directed self-checking bench for dual_pri_drain.
module tb_dual_pri_drain;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  dual_pri_drain_if #(.WIDTH(8), .IDX_W(3)) bus ();

  dual_pri_drain #(.WIDTH(8), .IDX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input int f, input int s, input int sv,
                            input int lst);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".first"}, 32'(bus.out_first), 32'(f));
    check({tag, ".second"}, 32'(bus.out_second), 32'(s));
    check({tag, ".svld"}, 32'(bus.out_second_vld), 32'(sv));
    check({tag, ".last"}, 32'(bus.out_last), 32'(lst));
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic offer(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec   = 8'h00;
    bus.out_ready = 1'b1;

    // Reset values
    step();
    check_idle("rst");
    check("rst.first", 32'(bus.out_first), 32'd0);
    check("rst.second", 32'(bus.out_second), 32'd0);
    check("rst.svld", 32'(bus.out_second_vld), 32'd0);
    check("rst.last", 32'(bus.out_last), 32'd0);
    rst_n = 1'b1;
    step();

    // 1000_0010: single beat (7,1)
    offer(8'b1000_0010);
    #1 check("t1.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check_beat("t1", 7, 1, 1, 1);
    step();
    check_idle("t1.after");

    // FF: four beats; input offered mid-drain must be refused
    offer(8'hFF);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) offer(8'h01);
      else bus.in_valid = 1'b0;
      #1;
      check_beat($sformatf("t2.b%0d", k), 7 - 2 * k, 6 - 2 * k, 1, (k == 3) ? 1 : 0);
      check($sformatf("t2.b%0d.in_ready", k), 32'(bus.in_ready), (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    check_idle("t2.after");

    // 0000_0001: single bit, then a zero vector is swallowed
    offer(8'b0000_0001);
    step();
    bus.in_valid = 1'b0;
    check_beat("t3", 0, 0, 0, 1);
    step();
    offer(8'h00);
    #1 check("t3.zero.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check_idle("t3.zero");
    step();
    check_idle("t3.zero2");

    // 0010_0100 with stalled consumer
    offer(8'b0010_0100);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_beat($sformatf("t4.hold%0d", k), 5, 2, 1, 1);
      step();
    end
    bus.out_ready = 1'b1;
    check_beat("t4.take", 5, 2, 1, 1);
    step();
    check_idle("t4.after");

    // Back-to-back reload on the last beat
    offer(8'b0000_1100);
    step();
    check_beat("t5.b0", 3, 2, 1, 1);
    offer(8'b0100_0000);
    #1 check("t5.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check_beat("t5.b1", 6, 0, 0, 1);
    step();
    check_idle("t5.after");

    // Reset mid-drain after the first beat of F0
    offer(8'hF0);
    step();
    bus.in_valid = 1'b0;
    check_beat("t6.b0", 7, 6, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst.valid", 32'(bus.out_valid), 32'd0);
    check("t6.rst.busy", 32'(bus.busy), 32'd0);
    check("t6.rst.first", 32'(bus.out_first), 32'd0);
    step();
    rst_n = 1'b1;
    #1 check_idle("t6.release");
    step();
    check_idle("t6.no_beat");
    step();
    check_idle("t6.no_beat2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
